regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 8x16 architectural register file between NUM_REQ

---
 rtl/regfile_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter: per-lane queues feeding the single
// register file write port, with a pending-write mask for hazard stalls.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [2**ADDR_W-1:0]      pending_mask
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int LW   = $clog2(NUM_REQ);
  localparam int NREG = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t        mem_q [NUM_REQ][FIFO_DEPTH];
  entry_t        mem_d [NUM_REQ][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q [NUM_REQ];
  logic [PW-1:0] rd_ptr_d [NUM_REQ];
  logic [PW-1:0] wr_ptr_q [NUM_REQ];
  logic [PW-1:0] wr_ptr_d [NUM_REQ];
  logic [CW-1:0] count_q [NUM_REQ];
  logic [CW-1:0] count_d [NUM_REQ];

  logic [LW-1:0]     last_grant_q;
  logic [LW-1:0]     last_grant_d;
  logic              rf_we_q;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [ADDR_W-1:0] rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q;
  logic [DATA_W-1:0] rf_wdata_d;

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] nonempty;
  logic               grant_vld;
  logic [LW-1:0]      grant_idx;
  entry_t             head;
  logic [NREG-1:0]    pend;

  always_comb begin
    req_ready = '0;
    nonempty  = '0;
    push      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = count_q[i] < CW'(FIFO_DEPTH);
      nonempty[i]  = count_q[i] != '0;
      push[i]      = req_valid[i] && req_ready[i];
    end
  end

  // Descending scan so the lane closest after last_grant wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (nonempty[(int'(last_grant_q) + 1 + k) % NUM_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = LW'((int'(last_grant_q) + 1 + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = grant_vld && (grant_idx == LW'(i));
    end
    head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]].addr = req_addr[i*ADDR_W +: ADDR_W];
        mem_d[i][wr_ptr_q[i]].data = req_data[i*DATA_W +: DATA_W];
      end
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    rf_we_d      = grant_vld;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    if (grant_vld) begin
      rf_waddr_d   = head.addr;
      rf_wdata_d   = head.data;
      last_grant_d = grant_idx;
    end
  end

  // An entry is live when its distance from rd_ptr is below count.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if ({1'b0, PW'(PW'(j) - rd_ptr_q[i])} < count_q[i]) begin
          pend[mem_q[i][j].addr] = 1'b1;
        end
      end
    end
    if (rf_we_q) begin
      pend[rf_waddr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      last_grant_q <= LW'(NUM_REQ - 1);
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign pending_mask = pend;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus hand sequences for reset, streaming
// backpressure and mid-operation reset of regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  pending_mask;

  int total = 0;
  int bad = 0;

  regfile_wb_arbiter #(
    .NUM_REQ(2), .DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic [2:0]  a0;
    logic [15:0] d0;
    logic [2:0]  a1;
    logic [15:0] d1;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [7:0]  pm;
    logic [1:0]  rdy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [2:0] a0, input logic [15:0] d0,
                       input logic [2:0] a1, input logic [15:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic chk_out(input string nm, input logic we,
                         input logic [7:0] pm, input logic [1:0] rdy);
    chk({nm, "_we"}, 32'(rf_we), 32'(we));
    chk({nm, "_pm"}, 32'(pending_mask), 32'(pm));
    chk({nm, "_rdy"}, 32'(req_ready), 32'(rdy));
  endtask

  initial begin
    int idx [2];
    int wr [2];
    int nw;
    int prev;
    int lane;
    bit saw_bp;
    logic [1:0] acc;

    tbl[0]  = '{2'b01, 3'd3, 16'h1234, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 8'h08, 2'b11};
    tbl[1]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 8'h08, 2'b11};
    tbl[2]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd3, 16'h1234, 8'h00, 2'b11};
    tbl[3]  = '{2'b11, 3'd4, 16'hCCCC, 3'd5, 16'hDDDD, 1'b0, 3'd3, 16'h1234, 8'h30, 2'b11};
    tbl[4]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd5, 16'hDDDD, 8'h30, 2'b11};
    tbl[5]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd4, 16'hCCCC, 8'h10, 2'b11};
    tbl[6]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd4, 16'hCCCC, 8'h00, 2'b11};
    tbl[7]  = '{2'b11, 3'd5, 16'h0001, 3'd5, 16'h0002, 1'b0, 3'd4, 16'hCCCC, 8'h20, 2'b11};
    tbl[8]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h0002, 8'h20, 2'b11};
    tbl[9]  = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd5, 16'h0001, 8'h20, 2'b11};
    tbl[10] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd5, 16'h0001, 8'h00, 2'b11};
    tbl[11] = '{2'b11, 3'd0, 16'h1111, 3'd1, 16'h2222, 1'b0, 3'd5, 16'h0001, 8'h03, 2'b11};
    tbl[12] = '{2'b11, 3'd2, 16'h3333, 3'd3, 16'h4444, 1'b1, 3'd1, 16'h2222, 8'h0F, 2'b10};
    tbl[13] = '{2'b11, 3'd6, 16'h5555, 3'd7, 16'h6666, 1'b1, 3'd0, 16'h1111, 8'h8D, 2'b01};
    tbl[14] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h4444, 8'h8C, 2'b11};
    tbl[15] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd2, 16'h3333, 8'h84, 2'b11};
    tbl[16] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b1, 3'd7, 16'h6666, 8'h80, 2'b11};
    tbl[17] = '{2'b00, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 3'd7, 16'h6666, 8'h00, 2'b11};

    // Reset held two edges with both lanes offering.
    reset = 1'b0;
    drive(2'b11, 3'd1, 16'hFFFF, 3'd2, 16'hEEEE);
    tick();
    tick();
    chk_out("rst", 1'b0, 8'h00, 2'b11);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    reset = 1'b1;
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    chk_out("rst_idle", 1'b0, 8'h00, 2'b11);

    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].v, tbl[r].a0, tbl[r].d0, tbl[r].a1, tbl[r].d1);
      tick();
      chk($sformatf("v%0d_we", r), 32'(rf_we), 32'(tbl[r].we));
      chk($sformatf("v%0d_wa", r), 32'(rf_waddr), 32'(tbl[r].wa));
      chk($sformatf("v%0d_wd", r), 32'(rf_wdata), 32'(tbl[r].wd));
      chk($sformatf("v%0d_pm", r), 32'(pending_mask), 32'(tbl[r].pm));
      chk($sformatf("v%0d_rdy", r), 32'(req_ready), 32'(tbl[r].rdy));
    end

    // Both lanes stream 8 tagged beats; data = {lane tag, index}.
    idx = '{0, 0};
    wr = '{0, 0};
    nw = 0;
    prev = -1;
    saw_bp = 1'b0;
    for (int cyc = 0; cyc < 100 && nw < 16; cyc++) begin
      req_valid[0] = idx[0] < 8;
      req_valid[1] = idx[1] < 8;
      req_addr  = {3'(idx[1]), 3'(idx[0])};
      req_data  = {8'hB0, 8'(idx[1]), 8'hA0, 8'(idx[0])};
      acc = req_valid & req_ready;
      if (req_valid != 2'b00 && req_ready != 2'b11) saw_bp = 1'b1;
      tick();
      if (acc[0]) idx[0]++;
      if (acc[1]) idx[1]++;
      if (rf_we) begin
        lane = (rf_wdata[15:8] == 8'hA0) ? 0 : 1;
        chk($sformatf("strm_ord%0d", nw), 32'(rf_wdata[7:0]), 32'(wr[lane]));
        if (prev >= 0) begin
          chk($sformatf("strm_alt%0d", nw), 32'(lane), 32'(1 - prev));
        end
        wr[lane]++;
        prev = lane;
        nw++;
      end
    end
    req_valid = 2'b00;
    chk("strm_count", 32'(nw), 32'd16);
    chk("strm_lane0", 32'(wr[0]), 32'd8);
    chk("strm_lane1", 32'(wr[1]), 32'd8);
    chk("strm_bp", 32'(saw_bp), 32'd1);
    tick();
    chk_out("strm_end", 1'b0, 8'h00, 2'b11);

    // Queue work on both lanes, then a single reset edge.
    drive(2'b11, 3'd1, 16'h0101, 3'd2, 16'h0202);
    tick();
    drive(2'b11, 3'd3, 16'h0303, 3'd4, 16'h0404);
    tick();
    chk("pre_rst_pm", 32'(pending_mask != 8'h00), 32'd1);
    reset = 1'b0;
    drive(2'b11, 3'd6, 16'h0606, 3'd7, 16'h0707);
    tick();
    chk_out("mid_rst", 1'b0, 8'h00, 2'b11);
    reset = 1'b1;
    drive(2'b01, 3'd3, 16'h1234, 3'd0, 16'h0000);
    tick();
    chk_out("post_acc", 1'b0, 8'h08, 2'b11);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    chk_out("post_wr", 1'b1, 8'h08, 2'b11);
    chk("post_wa", 32'(rf_waddr), 32'd3);
    chk("post_wd", 32'(rf_wdata), 32'h1234);
    tick();
    chk_out("post_idle", 1'b0, 8'h00, 2'b11);

    // Fresh reset, then a simultaneous pair: lane0 has priority.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(2'b11, 3'd1, 16'hAAAA, 3'd2, 16'hBBBB);
    tick();
    chk_out("pair_acc", 1'b0, 8'h06, 2'b11);
    drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
    tick();
    chk_out("pair_w0", 1'b1, 8'h06, 2'b11);
    chk("pair_w0_wa", 32'(rf_waddr), 32'd1);
    chk("pair_w0_wd", 32'(rf_wdata), 32'hAAAA);
    tick();
    chk_out("pair_w1", 1'b1, 8'h04, 2'b11);
    chk("pair_w1_wa", 32'(rf_waddr), 32'd2);
    chk("pair_w1_wd", 32'(rf_wdata), 32'hBBBB);
    tick();
    chk_out("pair_end", 1'b0, 8'h00, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
